// File: rtl/ps2_move_decoder_pkg.sv
// Package ps2_move_pkg: shared constants and types for the PS/2 movement decoder.
//  - PS/2 set-2 scan codes for the prefix bytes and the keys the game uses
//  - 3-bit direction encodings, shared with the MonumentValley game core
//  - prefix FSM state encoding
//  - map_dir(): key map from {extended, code} to a direction (DIR_NONE when unmapped)
package ps2_move_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [2:0] DIR_NONE  = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b111;
  localparam logic [2:0] DIR_LEFT  = 3'b101;
  localparam logic [2:0] DIR_DOWN  = 3'b100;
  localparam logic [2:0] DIR_RIGHT = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_t;

  // Letters are non-extended codes; arrows only count with the E0 prefix
  // (a bare 75/6B/72/74 is the numeric keypad and is deliberately unmapped).
  function automatic logic [2:0] map_dir(input logic ext, input logic [7:0] code);
    logic [2:0] d;
    case ({ext, code})
      {1'b0, SC_W},     {1'b1, SC_UP}:    d = DIR_UP;
      {1'b0, SC_A},     {1'b1, SC_LEFT}:  d = DIR_LEFT;
      {1'b0, SC_S},     {1'b1, SC_DOWN}:  d = DIR_DOWN;
      {1'b0, SC_D},     {1'b1, SC_RIGHT}: d = DIR_RIGHT;
      default:                            d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ps2_move_decoder_if.sv
// Interface ps2_move_if: byte stream in from PS2_Controller, movement controls out.
//  received_data[7:0]  scan-code byte          (master -> slave)
//  received_data_en    one-clock byte strobe   (master -> slave)
//  move                key held level          (slave -> master)
//  dir[2:0]            held direction          (slave -> master)
//  step                one-clock step pulse    (slave -> master)
//  activate            one-clock space pulse   (slave -> master)
interface ps2_move_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       move;
  logic [2:0] dir;
  logic       step;
  logic       activate;

  modport master (
    output received_data, received_data_en,
    input  move, dir, step, activate
  );

  modport slave (
    input  received_data, received_data_en,
    output move, dir, step, activate
  );
endinterface

// File: rtl/ps2_move_decoder_timer.sv
// Module ps2_repeat_timer: auto-repeat down-counter.
//  clock, resetn  clock and asynchronous active-low reset
//  load_value     count loaded on load (cycles-1 until the first expiry)
//  load           restart the countdown from load_value (wins over everything)
//  enable         count while high; when low the counter is parked at zero
//  expire         combinational: counter at zero while enabled; it then
//                 reloads REPEAT_CYCLES-1 so expiries are REPEAT_CYCLES apart
module ps2_repeat_timer #(
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int WIDTH         = 23
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load,
  input  logic             enable,
  output logic             expire
);

  localparam logic [WIDTH-1:0] RELOAD = WIDTH'(REPEAT_CYCLES - 1);
  localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_r;

  assign expire = enable && !load && (count_r == ZERO);

  // Countdown register: load, park, reload at zero (never wraps), decrement.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_r <= ZERO;
    end else if (load) begin
      count_r <= load_value;
    end else if (!enable) begin
      count_r <= ZERO;
    end else if (count_r == ZERO) begin
      count_r <= RELOAD;
    end else begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/ps2_move_decoder.sv
// Module ps2_move_decoder: PS/2 scan-code stream to game movement controls.
//  clock    system clock (CLOCK_50)
//  resetn   asynchronous active-low reset
//  bus      ps2_move_if.slave: received_data/received_data_en in;
//           move, dir, step, activate out (all registered, one clock after
//           the strobe that completes a code)
//  Tracks E0/F0 prefixes, remembers the held key as {ext,code}, pulses step
//  on a new press and then after FIRST_DELAY and every REPEAT_CYCLES clocks.
module ps2_move_decoder
  import ps2_move_pkg::*;
#(
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int FIRST_DELAY   = 15_000_000
) (
  input  logic        clock,
  input  logic        resetn,
  ps2_move_if.slave   bus
);

  localparam int MAX_DELAY = (FIRST_DELAY > REPEAT_CYCLES) ? FIRST_DELAY : REPEAT_CYCLES;
  localparam int TW        = $clog2(MAX_DELAY + 1);
  // Counter expires when it reaches zero, so load one less than the delay.
  localparam logic [TW-1:0] FIRST_LOAD = TW'(FIRST_DELAY - 1);

  prefix_state_t state_r, state_s;
  logic [8:0]    held_r, held_s;
  logic [2:0]    dir_r, dir_s;
  logic          move_r, move_s;
  logic          step_r, step_s;
  logic          act_r, act_s;

  logic          make_s, brk_s, key_ext_s;
  logic [8:0]    key_s;
  logic [2:0]    map_s;
  logic          press_s, release_s, timer_en_s, expire_s;

  // Prefix FSM next state and classification of the completed code.
  always_comb begin
    state_s   = state_r;
    make_s    = 1'b0;
    brk_s     = 1'b0;
    key_ext_s = 1'b0;
    if (bus.received_data_en) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.received_data == SC_EXT) begin
            state_s = ST_EXT;
          end else if (bus.received_data == SC_BRK) begin
            state_s = ST_BRK;
          end else begin
            make_s = 1'b1;
          end
        end
        ST_EXT: begin
          if (bus.received_data == SC_BRK) begin
            state_s = ST_EXT_BRK;
          end else if (bus.received_data == SC_EXT) begin
            state_s = ST_EXT;
          end else begin
            make_s    = 1'b1;
            key_ext_s = 1'b1;
            state_s   = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk_s   = 1'b1;
          state_s = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk_s     = 1'b1;
          key_ext_s = 1'b1;
          state_s   = ST_IDLE;
        end
        default: state_s = ST_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  assign key_s      = {key_ext_s, bus.received_data};
  assign map_s      = map_dir(key_ext_s, bus.received_data);
  // A typematic repeat of the held key is not a new press.
  assign press_s    = make_s && (map_s != DIR_NONE) && (key_s != held_r);
  assign release_s  = brk_s && move_r && (key_s == held_r);
  // Stopping on release also masks a same-cycle expiry, so break wins.
  assign timer_en_s = move_r && !release_s;

  ps2_repeat_timer #(
    .REPEAT_CYCLES (REPEAT_CYCLES),
    .WIDTH         (TW)
  ) u_timer (
    .clock      (clock),
    .resetn     (resetn),
    .load_value (FIRST_LOAD),
    .load       (press_s),
    .enable     (timer_en_s),
    .expire     (expire_s)
  );

  // Next values of the held key and movement outputs.
  always_comb begin
    held_s = held_r;
    dir_s  = dir_r;
    move_s = move_r;
    step_s = 1'b0;
    act_s  = make_s && (key_s == {1'b0, SC_SPACE});
    if (press_s) begin
      // A new press always gives exactly one step, even on an expiry cycle.
      held_s = key_s;
      dir_s  = map_s;
      move_s = 1'b1;
      step_s = 1'b1;
    end else if (release_s) begin
      held_s = 9'h000;
      dir_s  = DIR_NONE;
      move_s = 1'b0;
      step_s = 1'b0;
    end else begin
      step_s = expire_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      held_r  <= 9'h000;
      dir_r   <= DIR_NONE;
      move_r  <= 1'b0;
      step_r  <= 1'b0;
      act_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      held_r  <= held_s;
      dir_r   <= dir_s;
      move_r  <= move_s;
      step_r  <= step_s;
      act_r   <= act_s;
    end
  end

  assign bus.move     = move_r;
  assign bus.dir      = dir_r;
  assign bus.step     = step_r;
  assign bus.activate = act_r;

endmodule
